frontend_inst_queue: RTL and testbench
======================================

# frontend_inst_queue

Dual-issue instruction queue between the fetch stage (instruction cache plus branch predictor outputs) and the backend decoder. It accepts up to two fetched instructions per cycle with their prediction and exception tags, and buffers them in a circular FIFO. It presents the two oldest entries to the decoder and retires 0–2 entries per cycle according to the decoder's `send_inst_en`. It is the producer end of the `pc`/`inst`/`send_inst_en`/`pause_buffer` handshake consumed by `backend_top`.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥4
- `DECODER_WIDTH`, 2: fetch width and issue width (package constant; fixed at 2)
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: discard all entries (ctrl flush of the queue stage)
- `fetch_valid` in [1:0]: per-slot valid from fetch; slot 1 valid only if slot 0 valid
- `fetch_pc`, `fetch_inst` in [1:0] x bus32_t: fetched PC and instruction
- `fetch_pre_is_branch`, `fetch_pre_is_branch_taken` in [1:0]: BPU prediction bits
- `fetch_pre_branch_addr` in [1:0] x bus32_t: predicted target
- `fetch_is_exception` in [1:0][5:0]: exception flags
- `fetch_exception_cause` in [1:0][5:0][6:0]: exception causes
- `fetch_stall` out 1: fetch must hold; push is refused
- `send_inst_en` in [1:0]: decoder consumes output slot k
- `pc`, `inst`, `pre_is_branch`, `pre_is_branch_taken`, `pre_branch_addr`, `is_exception`, `exception_cause` out: slot 0 carries the head entry, slot 1 carries head+1; same widths as the fetch inputs
- `out_valid` out [1:0]: output slot holds a real entry
- `pause_buffer` out 1: queue empty

## Operation
- Storage: DEPTH entries; `head` and `tail` are log2(DEPTH)-bit pointers that wrap modulo DEPTH; `count` is log2(DEPTH)+1 bits.
- `free` = DEPTH − `count`. `fetch_stall` = (`free` < 2), computed combinationally from registered `count` only.
- Push:
  - `n_push` = popcount(`fetch_valid`) when `fetch_stall`=0, else 0.
  - Slot 0 is written to `tail`, slot 1 to `tail`+1.
  - `tail` advances by `n_push`. Push is all-or-nothing per cycle.
- Pop:
  - `n_pop` = `send_inst_en[0]&out_valid[0]` + `send_inst_en[0]&send_inst_en[1]&out_valid[1]`.
  - `send_inst_en`=2'b10 pops nothing; in-order retirement is mandatory.
  - `head` advances by `n_pop`.
- `count_next` = `count` + `n_push` − `n_pop`. Push and pop in the same cycle are legal, including at `count`=DEPTH−2 and `count`=0.
- `out_valid[0]` = (`count`≥1); `out_valid[1]` = (`count`≥2). Data outputs for an invalid slot are forced to zero.
- `pause_buffer` = (`count`==0).
- Flush:
  - Next cycle: `head`=`tail`=`count`=0.
  - Overrides push and pop in the flush cycle; fetch data arriving that cycle is dropped.
- Reset:
  - `head`/`tail`/`count`=0, storage need not be cleared.
  - Outputs: `out_valid`=0, `pause_buffer`=1, `fetch_stall`=0, all data outputs 0.
- A write into the FIFO is never dropped; entries that are not popped remain unchanged.

## Timing
- Push-to-output latency is 1 cycle: an entry written in cycle N is visible at an output slot in cycle N+1.
- Output slots are a combinational read of registered storage at `head`/`head`+1. No read-through bypass of same-cycle pushes.
- `fetch_stall` uses pre-pop `count`. It is conservative by up to one cycle of throughput.
- Back-to-back 2-in/2-out sustains 2 instructions per cycle at steady state.

## Configuration
- `INST_QUEUE_PERF_EN` defined:
  - Adds outputs `perf_full_cycles` and `perf_empty_cycles`, 32 bits each.
  - They count cycles with `fetch_stall`=1 and `pause_buffer`=1 respectively.
  - Both saturate at 32'hFFFF_FFFF, clear only on `rst`, and are unaffected by `flush`.
- `INST_QUEUE_PERF_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- `pipeline_types` holds:
  - `inst_queue_entry_t`: pc, inst, pre_is_branch, pre_is_branch_taken, pre_branch_addr, is_exception, exception_cause.
  - Constant `INST_QUEUE_DEPTH`.
- Sub-module `inst_queue_ram`: DEPTH x `inst_queue_entry_t`, 2 write ports, 2 asynchronous read ports. Pointer and count logic stays in the top.

## Test plan
- Reset, then push pc 0x1c000000/0x1c000004 with `send_inst_en`=0 → next cycle `out_valid`=2'b11, `pc`={0x1c000004,0x1c000000}, `pause_buffer`=0.
- Push 2 per cycle, no pops, DEPTH=16 → `fetch_stall`=1 once `count`=15 or 16; a further push is refused and the 16th entry's pc is not overwritten.
- Fill to 14, then push 2 and pop 2 each cycle for 20 cycles → `count` holds at 14, pointers wrap, pcs emerge strictly in order.
- `count`=1 with `send_inst_en`=2'b11 → only 1 pop, `count`=0, `pause_buffer`=1; `send_inst_en`=2'b10 with `count`=3 → `count` stays 3.
- `count`=9, flush asserted together with a push and a pop → next cycle `count`=0, `out_valid`=0, data outputs 0.
- With `INST_QUEUE_PERF_EN` defined: 5 empty cycles after reset → `perf_empty_cycles`=5; a flush leaves it unchanged.

Source files
------------

// File: rtl/frontend_inst_queue_pkg.sv
// Shared types and constants for the frontend instruction queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package frontend_inst_queue_pkg;

    localparam int DECODER_WIDTH    = 2;
    localparam int INST_QUEUE_DEPTH = 16;

    typedef logic [31:0] bus32_t;

    // One buffered fetch slot: instruction plus its prediction and exception tags.
    typedef struct packed {
        bus32_t          pc;
        bus32_t          inst;
        logic            pre_is_branch;
        logic            pre_is_branch_taken;
        bus32_t          pre_branch_addr;
        logic [5:0]      is_exception;
        logic [5:0][6:0] exception_cause;
    } inst_queue_entry_t;

endpackage

// File: rtl/frontend_inst_queue_if.sv
// Fetch-to-decoder bundle around the instruction queue.
// Latency: n/a (wiring only).
// Backpressure: fetch_stall toward fetch, send_inst_en from the decoder.
// Ports: fetch_* slot inputs and fetch_stall; pc/inst/... output slots,
// out_valid, pause_buffer and send_inst_en. The master modport is the queue.
interface frontend_inst_queue_if;
    import frontend_inst_queue_pkg::*;

    logic   [DECODER_WIDTH-1:0]            fetch_valid;
    bus32_t [DECODER_WIDTH-1:0]            fetch_pc;
    bus32_t [DECODER_WIDTH-1:0]            fetch_inst;
    logic   [DECODER_WIDTH-1:0]            fetch_pre_is_branch;
    logic   [DECODER_WIDTH-1:0]            fetch_pre_is_branch_taken;
    bus32_t [DECODER_WIDTH-1:0]            fetch_pre_branch_addr;
    logic   [DECODER_WIDTH-1:0][5:0]       fetch_is_exception;
    logic   [DECODER_WIDTH-1:0][5:0][6:0]  fetch_exception_cause;
    logic                                  fetch_stall;

    logic   [DECODER_WIDTH-1:0]            send_inst_en;
    bus32_t [DECODER_WIDTH-1:0]            pc;
    bus32_t [DECODER_WIDTH-1:0]            inst;
    logic   [DECODER_WIDTH-1:0]            pre_is_branch;
    logic   [DECODER_WIDTH-1:0]            pre_is_branch_taken;
    bus32_t [DECODER_WIDTH-1:0]            pre_branch_addr;
    logic   [DECODER_WIDTH-1:0][5:0]       is_exception;
    logic   [DECODER_WIDTH-1:0][5:0][6:0]  exception_cause;
    logic   [DECODER_WIDTH-1:0]            out_valid;
    logic                                  pause_buffer;

    modport master (
        input  fetch_valid, fetch_pc, fetch_inst, fetch_pre_is_branch,
               fetch_pre_is_branch_taken, fetch_pre_branch_addr,
               fetch_is_exception, fetch_exception_cause, send_inst_en,
        output fetch_stall, pc, inst, pre_is_branch, pre_is_branch_taken,
               pre_branch_addr, is_exception, exception_cause, out_valid,
               pause_buffer
    );

    modport slave (
        output fetch_valid, fetch_pc, fetch_inst, fetch_pre_is_branch,
               fetch_pre_is_branch_taken, fetch_pre_branch_addr,
               fetch_is_exception, fetch_exception_cause, send_inst_en,
        input  fetch_stall, pc, inst, pre_is_branch, pre_is_branch_taken,
               pre_branch_addr, is_exception, exception_cause, out_valid,
               pause_buffer
    );

endinterface

// File: rtl/frontend_inst_queue_ram.sv
// Entry storage: DEPTH x inst_queue_entry_t, 2 write ports, 2 async read ports.
// Latency: write visible on the read ports the cycle after the write edge.
// Backpressure: none; the caller decides when to write.
// Ports: clk, we/waddr/wdata per write port, raddr/rdata per read port.
module inst_queue_ram
    import frontend_inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  inst_queue_entry_t wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  inst_queue_entry_t wdata1,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    output inst_queue_entry_t rdata0,
    output inst_queue_entry_t rdata1
);

    inst_queue_entry_t mem [DEPTH];

    // The two write addresses are always distinct (tail, tail+1), so the
    // ordering of the two writes never matters.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/frontend_inst_queue.sv
// Dual-issue instruction queue between fetch and the backend decoder.
// Latency: 1 cycle push-to-output; outputs are a combinational read at head/head+1.
// Backpressure: fetch_stall when fewer than 2 free entries (pre-pop count);
// decoder retires in order via send_inst_en.
// Ports: clk, rst (async active-high), flush, bus (master modport).
// Optional INST_QUEUE_PERF_EN adds perf_full_cycles / perf_empty_cycles.
module frontend_inst_queue
    import frontend_inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    frontend_inst_queue_if.master       bus
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0]                 perf_full_cycles,
    output logic [31:0]                 perf_empty_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic [AW:0]       free;
    logic              we0;
    logic              we1;
    logic [1:0]        n_push;
    logic              pop0;
    logic              pop1;
    logic [1:0]        n_pop;
    inst_queue_entry_t wr_ent [DECODER_WIDTH];
    inst_queue_entry_t rd_ent [DECODER_WIDTH];
    inst_queue_entry_t out_ent [DECODER_WIDTH];

    // Stall depends only on registered count, so it never waits on the
    // decoder's same-cycle pop decision.
    assign free            = DEPTH_W - count;
    assign bus.fetch_stall = (free < (AW+1)'(2));

    assign we0    = ~bus.fetch_stall & bus.fetch_valid[0];
    assign we1    = ~bus.fetch_stall & bus.fetch_valid[1];
    assign n_push = {1'b0, we0} + {1'b0, we1};

    assign bus.out_valid[0] = (count >= (AW+1)'(1));
    assign bus.out_valid[1] = (count >= (AW+1)'(2));
    assign bus.pause_buffer = (count == '0);

    // Slot 1 may only retire together with slot 0, keeping retirement in order.
    assign pop0  = bus.send_inst_en[0] & bus.out_valid[0];
    assign pop1  = pop0 & bus.send_inst_en[1] & bus.out_valid[1];
    assign n_pop = {1'b0, pop0} + {1'b0, pop1};

    always_comb begin
        for (int k = 0; k < DECODER_WIDTH; k++) begin
            wr_ent[k].pc                  = bus.fetch_pc[k];
            wr_ent[k].inst                = bus.fetch_inst[k];
            wr_ent[k].pre_is_branch       = bus.fetch_pre_is_branch[k];
            wr_ent[k].pre_is_branch_taken = bus.fetch_pre_is_branch_taken[k];
            wr_ent[k].pre_branch_addr     = bus.fetch_pre_branch_addr[k];
            wr_ent[k].is_exception        = bus.fetch_is_exception[k];
            wr_ent[k].exception_cause     = bus.fetch_exception_cause[k];
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we0    (we0 & ~flush),
        .waddr0 (tail),
        .wdata0 (wr_ent[0]),
        .we1    (we1 & ~flush),
        .waddr1 (tail + AW'(1)),
        .wdata1 (wr_ent[1]),
        .raddr0 (head),
        .raddr1 (head + AW'(1)),
        .rdata0 (rd_ent[0]),
        .rdata1 (rd_ent[1])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_pop);
            tail  <= tail + AW'(n_push);
            count <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
        end
    end

    // Invalid slots read stale storage, so they are masked to zero.
    always_comb begin
        bus.pc                  = '0;
        bus.inst                = '0;
        bus.pre_is_branch       = '0;
        bus.pre_is_branch_taken = '0;
        bus.pre_branch_addr     = '0;
        bus.is_exception        = '0;
        bus.exception_cause     = '0;
        for (int k = 0; k < DECODER_WIDTH; k++) begin
            out_ent[k]                 = bus.out_valid[k] ? rd_ent[k] : '0;
            bus.pc[k]                  = out_ent[k].pc;
            bus.inst[k]                = out_ent[k].inst;
            bus.pre_is_branch[k]       = out_ent[k].pre_is_branch;
            bus.pre_is_branch_taken[k] = out_ent[k].pre_is_branch_taken;
            bus.pre_branch_addr[k]     = out_ent[k].pre_branch_addr;
            bus.is_exception[k]        = out_ent[k].is_exception;
            bus.exception_cause[k]     = out_ent[k].exception_cause;
        end
    end

`ifdef INST_QUEUE_PERF_EN
    // Saturating occupancy counters; flush intentionally does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (bus.fetch_stall && perf_full_cycles != 32'hFFFF_FFFF)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if (bus.pause_buffer && perf_empty_cycles != 32'hFFFF_FFFF)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frontend_inst_queue.sv
// Randomized and directed stimulus against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_frontend_inst_queue;
    import frontend_inst_queue_pkg::*;

    localparam int DEPTH = INST_QUEUE_DEPTH;

    logic clk;
    logic rst;
    logic flush;
`ifdef INST_QUEUE_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_empty_cycles;
`endif

    frontend_inst_queue_if bus ();

    frontend_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef INST_QUEUE_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue contents the decoder should currently see.
    inst_queue_entry_t exp_q [$];
    int unsigned       n_checks = 0;
    int unsigned       n_pass   = 0;
    logic [31:0]       next_pc;
    logic [31:0]       m_perf_full  = 0;
    logic [31:0]       m_perf_empty = 0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic inst_queue_entry_t rand_entry(input logic [31:0] pcv);
        inst_queue_entry_t e;
        logic [63:0] r;
        r                     = {$urandom, $urandom};
        e.pc                  = pcv;
        e.inst                = $urandom;
        e.pre_is_branch       = r[0];
        e.pre_is_branch_taken = r[1];
        e.pre_branch_addr     = $urandom;
        e.is_exception        = r[7:2];
        e.exception_cause     = {r[63:58], r[57:22]};
        return e;
    endfunction

    function automatic inst_queue_entry_t get_slot(input int k);
        inst_queue_entry_t e;
        e.pc                  = bus.pc[k];
        e.inst                = bus.inst[k];
        e.pre_is_branch       = bus.pre_is_branch[k];
        e.pre_is_branch_taken = bus.pre_is_branch_taken[k];
        e.pre_branch_addr     = bus.pre_branch_addr[k];
        e.is_exception        = bus.is_exception[k];
        e.exception_cause     = bus.exception_cause[k];
        return e;
    endfunction

    function automatic inst_queue_entry_t get_fetch(input int k);
        inst_queue_entry_t e;
        e.pc                  = bus.fetch_pc[k];
        e.inst                = bus.fetch_inst[k];
        e.pre_is_branch       = bus.fetch_pre_is_branch[k];
        e.pre_is_branch_taken = bus.fetch_pre_is_branch_taken[k];
        e.pre_branch_addr     = bus.fetch_pre_branch_addr[k];
        e.is_exception        = bus.fetch_is_exception[k];
        e.exception_cause     = bus.fetch_exception_cause[k];
        return e;
    endfunction

    // Monitor: compare visible outputs against the model, then advance the
    // model by what the coming clock edge should do.
    always @(negedge clk) begin
        int                size;
        logic              stall;
        int                npop;
        inst_queue_entry_t e0, e1;
        if (rst) begin
            exp_q.delete();
            m_perf_full  = 0;
            m_perf_empty = 0;
        end
        size  = exp_q.size();
        stall = (DEPTH - size) < 2;
        e0    = (size >= 1) ? exp_q[0] : '0;
        e1    = (size >= 2) ? exp_q[1] : '0;
        chk("out_valid",    160'(bus.out_valid),    160'({size >= 2, size >= 1}));
        chk("pause_buffer", 160'(bus.pause_buffer), 160'(size == 0));
        chk("fetch_stall",  160'(bus.fetch_stall),  160'(stall));
        chk("slot0",        160'(get_slot(0)),      160'(e0));
        chk("slot1",        160'(get_slot(1)),      160'(e1));
`ifdef INST_QUEUE_PERF_EN
        chk("perf_full",  160'(perf_full_cycles),  160'(m_perf_full));
        chk("perf_empty", 160'(perf_empty_cycles), 160'(m_perf_empty));
`endif
        if (!rst) begin
            if (stall)     m_perf_full++;
            if (size == 0) m_perf_empty++;
            if (flush) begin
                exp_q.delete();
            end else begin
                npop = 0;
                if (bus.send_inst_en[0] && size >= 1) begin
                    npop = 1;
                    if (bus.send_inst_en[1] && size >= 2) npop = 2;
                end
                for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
                if (!stall) begin
                    if (bus.fetch_valid[0]) exp_q.push_back(get_fetch(0));
                    if (bus.fetch_valid[1]) exp_q.push_back(get_fetch(1));
                end
            end
        end
    end

    task automatic step(input logic [1:0] fv, input logic [1:0] se, input logic fl);
        inst_queue_entry_t e;
        for (int k = 0; k < 2; k++) begin
            e = rand_entry(next_pc);
            if (fv[k]) next_pc = next_pc + 32'd4;
            bus.fetch_pc[k]                  = e.pc;
            bus.fetch_inst[k]                = e.inst;
            bus.fetch_pre_is_branch[k]       = e.pre_is_branch;
            bus.fetch_pre_is_branch_taken[k] = e.pre_is_branch_taken;
            bus.fetch_pre_branch_addr[k]     = e.pre_branch_addr;
            bus.fetch_is_exception[k]        = e.is_exception;
            bus.fetch_exception_cause[k]     = e.exception_cause;
        end
        bus.fetch_valid  = fv;
        bus.send_inst_en = se;
        flush            = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] fv;
        rst     = 1'b1;
        flush   = 1'b0;
        next_pc = 32'h1c00_0000;
        bus.fetch_valid               = '0;
        bus.fetch_pc                  = '0;
        bus.fetch_inst                = '0;
        bus.fetch_pre_is_branch       = '0;
        bus.fetch_pre_is_branch_taken = '0;
        bus.fetch_pre_branch_addr     = '0;
        bus.fetch_is_exception        = '0;
        bus.fetch_exception_cause     = '0;
        bus.send_inst_en              = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset (empty-cycle counting), then the first pair.
        repeat (5) step(2'b00, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        chk("first_pc0", 160'(bus.pc[0]), 160'(32'h1c00_0000));
        chk("first_pc1", 160'(bus.pc[1]), 160'(32'h1c00_0004));

        // Fill to 15 via an odd count, try pushing while stalled.
        step(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() < 15; i++) step(2'b11, 2'b00, 1'b0);
        repeat (2) step(2'b11, 2'b00, 1'b0);
        // Pop one to 14, then fill to 16 and keep pushing against the stall.
        step(2'b00, 2'b01, 1'b0);
        repeat (3) step(2'b11, 2'b00, 1'b0);
        chk("full_count", 160'(exp_q.size()), 160'(16));

        // Steady 2-in/2-out at 14 entries with pointer wrap.
        for (int i = 0; i < 20 && exp_q.size() > 14; i++) step(2'b00, 2'b01, 1'b0);
        repeat (20) step(2'b11, 2'b11, 1'b0);

        // Drain to 1, then a double pop retires only one.
        for (int i = 0; i < 20 && exp_q.size() > 1; i++)
            step(2'b00, (exp_q.size() >= 3) ? 2'b11 : 2'b01, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        // Three entries, then slot-1-only enables must retire nothing.
        step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        repeat (2) step(2'b00, 2'b10, 1'b0);

        // Nine entries, flush together with push and pop.
        for (int i = 0; i < 20 && exp_q.size() < 9; i++)
            step((exp_q.size() <= 7) ? 2'b11 : 2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b1);
        repeat (2) step(2'b00, 2'b00, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 2))
                0:       fv = 2'b00;
                1:       fv = 2'b01;
                default: fv = 2'b11;
            endcase
            step(fv, 2'($urandom), ($urandom_range(0, 39) == 0));
        end
        step(2'b00, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
